inta_sequencer: RTL and testbench
=================================

INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
- REQ-001 SHALL have parameter INTA_LOW, default 2: cycles INTA_n and WR_n are held low per pulse (legal range 1..15).
- REQ-002 SHALL have parameter INTA_GAP, default 2: cycles INTA_n is high between the two INTA pulses (legal range 1..15).
- REQ-003 SHALL have parameter AEOI, default 0: 1 = no EOI write cycle is issued.
- REQ-004 SHALL have parameter EOI_CMD, default 8'h20: OCW2 byte written for EOI (non-specific EOI).
- REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
- REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
- REQ-007 SHALL have port INT, input, 1 bit: interrupt request from the PIC; asynchronous level.
- REQ-008 SHALL have port int_enable, input, 1 bit: core interrupt-enable flag.
- REQ-009 SHALL have port INTA_n, output, 1 bit: interrupt acknowledge to the PIC; active low.
- REQ-010 SHALL have port data_in, input, 8 bits: PIC data bus during INTA.
- REQ-011 SHALL have port vector, output, 8 bits: captured vector byte.
- REQ-012 SHALL have port vec_valid, output, 1 bit: vector is available to the core.
- REQ-013 SHALL have port vec_ready, input, 1 bit: core accepts the vector.
- REQ-014 SHALL have port eoi_req, input, 1 bit: core finished the service routine.
- REQ-015 SHALL have port WR_n, output, 1 bit: write strobe to the PIC; active low.
- REQ-016 SHALL have port A0, output, 1 bit: PIC address line.
- REQ-017 SHALL have port data_out, output, 8 bits: write data to the PIC.
- REQ-018 SHALL have port data_oe, output, 1 bit: data_out drive enable.
- REQ-019 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
- REQ-020 SHALL synchronise INT through a 2-flop synchroniser to form int_s; the raw INT SHALL never be used by the FSM.
- REQ-021 SHALL implement the FSM states IDLE, ACK1, GAP, ACK2, PRESENT, SERVICE, EOI_WR, EOI_REC.
- REQ-022 IDLE: when int_s=1 and int_enable=1 at a clk edge, SHALL go to ACK1; INTA_n SHALL go low in the same edge (registered output).
- REQ-023 ACK1: SHALL hold INTA_n low for exactly INTA_LOW cycles, then go to GAP.
- REQ-024 GAP: SHALL hold INTA_n high for exactly INTA_GAP cycles, then go to ACK2.
- REQ-025 ACK2: SHALL hold INTA_n low for exactly INTA_LOW cycles; data_in SHALL be registered into vector at the edge ending the last low cycle; then go to PRESENT.
- REQ-026 PRESENT: vec_valid SHALL be 1 and vector stable; a cycle with vec_valid=1 and vec_ready=1 completes the transfer; the next state SHALL be SERVICE if AEOI=0, else IDLE.
- REQ-027 vec_valid SHALL never be asserted outside PRESENT.
- REQ-028 SERVICE: SHALL wait for eoi_req=1, then go to EOI_WR; eoi_req SHALL be ignored in all other states.
- REQ-029 EOI_WR: WR_n SHALL be low and data_oe=1, data_out=EOI_CMD, A0=0 for exactly INTA_LOW cycles; data_out/A0 valid from the first low cycle.
- REQ-030 EOI_REC: WR_n SHALL be high, data_oe=1 for one cycle (hold time); then go to IDLE.
- REQ-031 One shared 4-bit down-counter SHALL time ACK1/GAP/ACK2/EOI_WR; it SHALL be loaded on state entry and never wrap.
- REQ-032 INT deasserting or int_enable dropping after leaving IDLE SHALL NOT abort the sequence; both INTA pulses always complete (the PIC supplies the spurious vector).
- REQ-033 When returning to IDLE with int_s=1 and int_enable=1, the next sequence SHALL start no earlier than one cycle after IDLE is entered, giving a minimum INTA_n high time of 1 cycle between sequences.
- REQ-034 vector SHALL hold its last captured value until the next ACK2 capture.
- REQ-035 busy SHALL be 0 only in IDLE.

Reset
- REQ-036 On rst_n=0 the block SHALL immediately enter IDLE regardless of state, including mid-pulse.
- REQ-037 Output reset values SHALL be: INTA_n=1, WR_n=1, A0=0, data_out=8'h00, data_oe=0, vector=8'h00, vec_valid=0, busy=0; the synchroniser flops and the counter SHALL clear to 0.
- REQ-038 After rst_n rises, the first sequence SHALL NOT start before int_s has propagated through the synchroniser (2 cycles minimum).

Verification
- REQ-039 Basic: INT=1, int_enable=1, data_in=8'h4B during ACK2, vec_ready=1 -> INTA_n low 2 cycles, high 2 cycles, low 2 cycles; vector=8'h4B; vec_valid for 1 cycle.
- REQ-040 EOI: after REQ-039, pulse eoi_req -> WR_n low 2 cycles with data_out=8'h20, A0=0, data_oe=1; then busy=0.
- REQ-041 AEOI=1 -> no WR_n pulse; IDLE the cycle after the vec_valid & vec_ready transfer.
- REQ-042 Backpressure: vec_ready=0 for 5 cycles -> vec_valid stays 1 and vector stable; transfer on the 6th cycle.
- REQ-043 INT drops during GAP -> second INTA pulse still issued; data_in=8'h4F (IR7 spurious) is captured.
- REQ-044 rst_n low during ACK2 -> INTA_n=1 and busy=0 asynchronously; vec_valid is never asserted.

Source files
------------

// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer for an 8259-style PIC.
// The sequencer synchronises INT and issues the two INTA pulses. It captures the
// vector byte on the second pulse and hands it to the core with a valid/ready
// handshake. Unless AEOI is set, it then writes a non-specific EOI command back
// to the PIC.
module inta_sequencer #(
  parameter int          INTA_LOW = 2,
  parameter int          INTA_GAP = 2,
  parameter int          AEOI     = 0,
  parameter logic [7:0]  EOI_CMD  = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       INT,
  input  logic       int_enable,
  output logic       INTA_n,
  input  logic [7:0] data_in,
  output logic [7:0] vector,
  output logic       vec_valid,
  input  logic       vec_ready,
  input  logic       eoi_req,
  output logic       WR_n,
  output logic       A0,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACK1    = 3'd1,
    GAP     = 3'd2,
    ACK2    = 3'd3,
    PRESENT = 3'd4,
    SERVICE = 3'd5,
    EOI_WR  = 3'd6,
    EOI_REC = 3'd7
  } state_t;

  // Counter load values: a phase of N cycles counts N-1 down to 0.
  localparam logic [3:0] LOW_LD = 4'(INTA_LOW - 1);
  localparam logic [3:0] GAP_LD = 4'(INTA_GAP - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       sync_p0;
  logic       int_s;

  // The decrement floors at zero so the phase counter can never wrap.
  function automatic logic [3:0] sat_dec(input logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction

  // Two-flop synchroniser for the asynchronous INT level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      int_s   <= 1'b0;
    end else begin
      sync_p0 <= INT;
      int_s   <= sync_p0;
    end
  end

  // Sequencer FSM. All bus outputs are registered and change with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      INTA_n    <= 1'b1;
      WR_n      <= 1'b1;
      A0        <= 1'b0;
      data_out  <= 8'h00;
      data_oe   <= 1'b0;
      vector    <= 8'h00;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A full IDLE cycle always separates two sequences, which guarantees
          // INTA_n is high for at least one cycle between them.
          if (int_s && int_enable) begin
            state  <= ACK1;
            cnt    <= LOW_LD;
            INTA_n <= 1'b0;
            busy   <= 1'b1;
          end
        end
        ACK1: begin
          if (cnt == 4'd0) begin
            state  <= GAP;
            cnt    <= GAP_LD;
            INTA_n <= 1'b1;
          end else begin
            cnt <= sat_dec(cnt);
          end
        end
        GAP: begin
          // INT and int_enable are deliberately ignored here: the second pulse
          // must always follow, so the PIC can return its spurious vector.
          if (cnt == 4'd0) begin
            state  <= ACK2;
            cnt    <= LOW_LD;
            INTA_n <= 1'b0;
          end else begin
            cnt <= sat_dec(cnt);
          end
        end
        ACK2: begin
          if (cnt == 4'd0) begin
            state     <= PRESENT;
            INTA_n    <= 1'b1;
            vector    <= data_in;
            vec_valid <= 1'b1;
          end else begin
            cnt <= sat_dec(cnt);
          end
        end
        PRESENT: begin
          if (vec_ready) begin
            vec_valid <= 1'b0;
            if (AEOI != 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= SERVICE;
            end
          end
        end
        SERVICE: begin
          if (eoi_req) begin
            state    <= EOI_WR;
            cnt      <= LOW_LD;
            WR_n     <= 1'b0;
            data_oe  <= 1'b1;
            data_out <= EOI_CMD;
            A0       <= 1'b0;
          end
        end
        EOI_WR: begin
          if (cnt == 4'd0) begin
            state <= EOI_REC;
            WR_n  <= 1'b1;
          end else begin
            cnt <= sat_dec(cnt);
          end
        end
        EOI_REC: begin
          // Data stays driven for one cycle after WR_n rises to give hold time.
          state   <= IDLE;
          data_oe <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          INTA_n    <= 1'b1;
          WR_n      <= 1'b1;
          data_oe   <= 1'b0;
          vec_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer. Two instances run side by side on the same stimulus:
// u0 uses AEOI=0 and u1 uses AEOI=1. A timeline model predicts every output of
// both instances, and directed scenarios add literal expectations.
module tb_inta_sequencer;

  localparam int L = 2;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       INT = 1'b0;
  logic       int_enable = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       vec_ready = 1'b0;
  logic       eoi_req = 1'b0;

  logic       inta_n    [2];
  logic [7:0] vector    [2];
  logic       vec_valid [2];
  logic       wr_n      [2];
  logic       a0        [2];
  logic [7:0] data_out  [2];
  logic       data_oe   [2];
  logic       busy      [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inta_sequencer #(.INTA_LOW(L), .INTA_GAP(G), .AEOI(0), .EOI_CMD(8'h20)) u0 (
    .clk(clk), .rst_n(rst_n), .INT(INT), .int_enable(int_enable),
    .INTA_n(inta_n[0]), .data_in(data_in), .vector(vector[0]),
    .vec_valid(vec_valid[0]), .vec_ready(vec_ready), .eoi_req(eoi_req),
    .WR_n(wr_n[0]), .A0(a0[0]), .data_out(data_out[0]), .data_oe(data_oe[0]),
    .busy(busy[0])
  );

  inta_sequencer #(.INTA_LOW(L), .INTA_GAP(G), .AEOI(1), .EOI_CMD(8'h20)) u1 (
    .clk(clk), .rst_n(rst_n), .INT(INT), .int_enable(int_enable),
    .INTA_n(inta_n[1]), .data_in(data_in), .vector(vector[1]),
    .vec_valid(vec_valid[1]), .vec_ready(vec_ready), .eoi_req(eoi_req),
    .WR_n(wr_n[1]), .A0(a0[1]), .data_out(data_out[1]), .data_oe(data_oe[1]),
    .busy(busy[1])
  );

  // Timeline model. mode: 0 idle, 1 acknowledge (t = cycles since the first
  // INTA edge), 2 vector presented, 3 in service, 4 EOI write (t = cycles since
  // WR_n fell).
  int         mode [2] = '{0, 0};
  int         t    [2] = '{0, 0};
  logic [7:0] mvec [2] = '{8'h00, 8'h00};
  logic       s1 = 1'b0;
  logic       s2 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        mode[k] <= 0;
        t[k]    <= 0;
        mvec[k] <= 8'h00;
      end
    end else begin
      s1 <= INT;
      s2 <= s1;
      for (int k = 0; k < 2; k++) begin
        case (mode[k])
          0: if (s2 && int_enable) begin mode[k] <= 1; t[k] <= 0; end
          1: if (t[k] == 2*L+G-1) begin mvec[k] <= data_in; mode[k] <= 2; end
             else t[k] <= t[k] + 1;
          2: if (vec_ready) mode[k] <= (k == 1) ? 0 : 3;
          3: if (eoi_req) begin mode[k] <= 4; t[k] <= 0; end
          4: if (t[k] == L) mode[k] <= 0; else t[k] <= t[k] + 1;
          default: mode[k] <= 0;
        endcase
      end
    end
  end

  function automatic logic exp_inta(input int m, input int tt);
    return !(m == 1 && (tt < L || (tt >= L+G && tt < 2*L+G)));
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      chk1($sformatf("inta_n%0d", k), inta_n[k], exp_inta(mode[k], t[k]));
      chk1($sformatf("busy%0d", k), busy[k], mode[k] != 0);
      chk1($sformatf("vec_valid%0d", k), vec_valid[k], mode[k] == 2);
      chk8($sformatf("vector%0d", k), vector[k], mvec[k]);
      chk1($sformatf("wr_n%0d", k), wr_n[k], !(mode[k] == 4 && t[k] < L));
      chk1($sformatf("data_oe%0d", k), data_oe[k], mode[k] == 4);
      chk1($sformatf("a0_%0d", k), a0[k], 1'b0);
      if (mode[k] == 4) chk8($sformatf("data_out%0d", k), data_out[k], 8'h20);
    end
  endtask

  int lo_cnt = 0;
  int vv_cnt = 0;
  int wr_cnt = 0;
  int vv1_cnt = 0;
  int wr1_cnt = 0;

  // One cycle: compare and tally at the falling edge, then return 1 time unit
  // after the next rising edge so new inputs are driven away from the edge.
  task automatic cycle();
    @(negedge clk);
    compare_all();
    if (inta_n[0] == 1'b0) lo_cnt++;
    if (vec_valid[0]) vv_cnt++;
    if (wr_n[0] == 1'b0) wr_cnt++;
    if (vec_valid[1]) vv1_cnt++;
    if (wr_n[1] == 1'b0) wr1_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic eoi_pulse();
    eoi_req = 1'b1;
    cycle();
    eoi_req = 1'b0;
    cycles(6);
  endtask

  int b_lo, b_vv, b_wr, b_vv1;

  initial begin
    // Reset values
    cycles(3);
    chk1("rst_inta_n", inta_n[0], 1'b1);
    chk1("rst_wr_n", wr_n[0], 1'b1);
    chk1("rst_a0", a0[0], 1'b0);
    chk8("rst_data_out", data_out[0], 8'h00);
    chk1("rst_data_oe", data_oe[0], 1'b0);
    chk8("rst_vector", vector[0], 8'h00);
    chk1("rst_vec_valid", vec_valid[0], 1'b0);
    chk1("rst_busy", busy[0], 1'b0);

    // Basic sequence, INT already high when reset is released
    rst_n = 1'b1; INT = 1'b1; int_enable = 1'b1; vec_ready = 1'b1; data_in = 8'h4B;
    b_lo = lo_cnt; b_vv = vv_cnt; b_vv1 = vv1_cnt;
    cycles(2);
    chk1("sync_latency_inta_n", inta_n[0], 1'b1);
    for (int i = 0; i < 10 && !busy[0]; i++) cycle();
    chk1("basic_started", busy[0], 1'b1);
    INT = 1'b0;
    cycles(12);
    chk_int("basic_inta_low_cycles", lo_cnt - b_lo, 4);
    chk_int("basic_vv_cycles", vv_cnt - b_vv, 1);
    chk8("basic_vector", vector[0], 8'h4B);
    chk1("basic_in_service", busy[0], 1'b1);
    chk_int("aeoi_vv_cycles", vv1_cnt - b_vv1, 1);
    chk1("aeoi_idle_after", busy[1], 1'b0);
    chk8("aeoi_vector", vector[1], 8'h4B);

    // EOI write
    b_wr = wr_cnt;
    eoi_pulse();
    chk_int("eoi_wr_low_cycles", wr_cnt - b_wr, 2);
    chk1("eoi_busy_after", busy[0], 1'b0);

    // Backpressure
    vec_ready = 1'b0; INT = 1'b1; data_in = 8'hA5;
    for (int i = 0; i < 20 && !vec_valid[0]; i++) cycle();
    chk1("bp_presented", vec_valid[0], 1'b1);
    INT = 1'b0;
    b_vv = vv_cnt;
    cycles(5);
    chk_int("bp_vv_hold", vv_cnt - b_vv, 5);
    chk1("bp_still_valid", vec_valid[0], 1'b1);
    vec_ready = 1'b1;
    cycle();
    chk_int("bp_vv_total", vv_cnt - b_vv, 6);
    chk1("bp_vv_dropped", vec_valid[0], 1'b0);
    chk8("bp_vector", vector[0], 8'hA5);
    eoi_pulse();

    // INT and int_enable drop during GAP: second pulse still issued
    data_in = 8'h00; INT = 1'b1;
    b_lo = lo_cnt;
    for (int i = 0; i < 20 && inta_n[0]; i++) cycle();
    for (int i = 0; i < 20 && !inta_n[0]; i++) cycle();
    chk1("gap_reached", busy[0], 1'b1);
    INT = 1'b0; int_enable = 1'b0; data_in = 8'h4F;
    cycles(10);
    chk_int("gap_inta_low_cycles", lo_cnt - b_lo, 4);
    chk8("gap_spurious_vector0", vector[0], 8'h4F);
    chk8("gap_spurious_vector1", vector[1], 8'h4F);
    eoi_pulse();

    // Reset asserted mid-cycle during ACK2
    int_enable = 1'b1; INT = 1'b1; data_in = 8'h77;
    b_lo = lo_cnt; b_vv = vv_cnt; b_vv1 = vv1_cnt;
    for (int i = 0; i < 20 && (lo_cnt - b_lo) < 3; i++) cycle();
    chk1("ack2_reached_inta_n", inta_n[0], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk1("async_rst_inta_n0", inta_n[0], 1'b1);
    chk1("async_rst_busy0", busy[0], 1'b0);
    chk1("async_rst_inta_n1", inta_n[1], 1'b1);
    chk1("async_rst_busy1", busy[1], 1'b0);
    INT = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(6);
    chk_int("rst_ack2_no_vv0", vv_cnt - b_vv, 0);
    chk_int("rst_ack2_no_vv1", vv1_cnt - b_vv1, 0);
    chk8("rst_ack2_vector", vector[0], 8'h00);
    chk_int("aeoi_never_wr", wr1_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
